packetizer_ta_mf: RTL



---
 rtl/packetizer_ta_mf.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/packetizer_ta_mf.sv
// ---------------------------------------------------------------------------
// packetizer_ta_mf
//
// Purpose:
//   Appends a tag to a data word, forming the payload P = {tag, data}, and
//   streams P out as NUM_FLITS NoC flits under valid/ready flow control.
//   Every flit carries {valid, head, tail, vc}. The head flit also carries
//   the destination. Payload bits are packed LSB-first: the head flit holds
//   P[HEAD_PAY-1:0], and each body flit holds the next BODY_PAY bits.
//   Unused bits in the last flit are zero. One packet is buffered. A new
//   packet may be accepted in the same cycle as the tail handshake, so
//   packets leave back-to-back.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   data_in    in   WIDTH_IN data word
//   valid_in   in   input valid
//   dst_in     in   ADDRESS_WIDTH destination router address
//   vc_in      in   VC_ADDRESS_WIDTH virtual channel
//   tag_in     in   WIDTH_TAG tag (ignored when the tag generator is built)
//   ready_out  out  input ready (combinational from ready_in on the tail flit)
//   data_out   out  WIDTH_OUT flit (zero when valid_out is low)
//   valid_out  out  flit valid
//   ready_in   in   fabric ready
//
// Build option:
//   PACKETIZER_TAG_GEN_EN - when defined, an internal WIDTH_TAG-bit counter
//   supplies the tag. It starts at 0 after reset and advances on every
//   accepted input.
// ---------------------------------------------------------------------------
module packetizer_ta_mf #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 64,
  parameter int WIDTH_TAG        = 8,
  parameter int WIDTH_OUT        = 36,
  parameter int NUM_FLITS        = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_IN-1:0]         data_in,
  input  logic                        valid_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  input  logic [WIDTH_TAG-1:0]        tag_in,
  output logic                        ready_out,
  output logic [WIDTH_OUT-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in
);

  localparam int PAY_W    = WIDTH_IN + WIDTH_TAG;
  localparam int HEAD_PAY = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int BODY_PAY = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH;
  localparam int CAP_W    = HEAD_PAY + (NUM_FLITS - 1) * BODY_PAY;
  localparam int IDX_W    = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int VC_MSB   = WIDTH_OUT - 4;
  localparam int DST_MSB  = WIDTH_OUT - 4 - VC_ADDRESS_WIDTH;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLITS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Reject configurations whose flits cannot hold the whole payload
  if ((NUM_FLITS < 1) || (NUM_FLITS > 8)) begin : g_bad_num_flits
    $fatal(1, "packetizer_ta_mf: NUM_FLITS must be within 1..8");
  end
  if (CAP_W < PAY_W) begin : g_bad_capacity
    $fatal(1, "packetizer_ta_mf: flits too small for tag+data payload");
  end

  logic [0:0]                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [PAY_W-1:0]            pay_q, pay_d;
  logic [ADDRESS_WIDTH-1:0]    dst_q, dst_d;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;

  logic                        busy_s;
  logic                        last_s;
  logic                        ready_s;
  logic                        accept_s;
  logic [WIDTH_TAG-1:0]        tag_s;
  logic [CAP_W-1:0]            pay_ext_s;
  logic [BODY_PAY-1:0]         body_pay_s;
  logic [WIDTH_OUT-1:0]        flit_s;

  assign busy_s   = (state_q == ST_SEND);
  assign last_s   = (idx_q == LAST_IDX);
  // The tail handshake frees the buffer in the same cycle, so a new packet
  // can be taken without a bubble.
  assign ready_s  = ~busy_s | (last_s & ready_in);
  assign accept_s = valid_in & ready_s;

`ifdef PACKETIZER_TAG_GEN_EN
  logic [WIDTH_TAG-1:0] tag_cnt_q, tag_cnt_d;
  logic                 unused_tag_s;

  assign unused_tag_s = ^tag_in;
  assign tag_s        = tag_cnt_q;

  // Tag counter next state: advance once per accepted packet, wrap naturally
  always_comb begin
    if (accept_s) begin
      tag_cnt_d = tag_cnt_q + WIDTH_TAG'(1);
    end else begin
      tag_cnt_d = tag_cnt_q;
    end
  end

  // Tag counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt_q <= '0;
    end else begin
      tag_cnt_q <= tag_cnt_d;
    end
  end
`else
  assign tag_s = tag_in;
`endif

  // Packet/FSM next state: capture on accept, otherwise advance on ready_in
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pay_d   = pay_q;
    dst_d   = dst_q;
    vc_d    = vc_q;
    if (accept_s) begin
      state_d = ST_SEND;
      idx_d   = '0;
      pay_d   = {tag_s, data_in};
      dst_d   = dst_in;
      vc_d    = vc_in;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SEND: begin
          if (ready_in) begin
            if (last_s) begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Packet and FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pay_q   <= '0;
      dst_q   <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      dst_q   <= dst_d;
      vc_q    <= vc_d;
    end
  end

  // Zero-extend the payload to the full flit capacity so the last flit pads with 0
  assign pay_ext_s = CAP_W'(pay_q);

  // Flit builder: decode purely from registered state, so the flit is stable
  // while ready_in is low
  always_comb begin
    flit_s     = '0;
    body_pay_s = '0;
    for (int k = 1; k < NUM_FLITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        body_pay_s = pay_ext_s[HEAD_PAY + (k - 1) * BODY_PAY +: BODY_PAY];
      end else begin
        body_pay_s = body_pay_s;
      end
    end
    if (busy_s) begin
      flit_s[WIDTH_OUT-1]               = 1'b1;
      flit_s[WIDTH_OUT-2]               = (idx_q == '0);
      flit_s[WIDTH_OUT-3]               = last_s;
      flit_s[VC_MSB -: VC_ADDRESS_WIDTH] = vc_q;
      if (idx_q == '0) begin
        flit_s[DST_MSB -: ADDRESS_WIDTH] = dst_q;
        flit_s[HEAD_PAY-1:0]             = pay_ext_s[HEAD_PAY-1:0];
      end else begin
        flit_s[BODY_PAY-1:0]             = body_pay_s;
      end
    end else begin
      flit_s = '0;
    end
  end

  assign data_out  = flit_s;
  assign valid_out = busy_s;
  assign ready_out = ready_s;

endmodule
